// File: rtl/melody_sequencer.sv
// Purpose: walks a note ROM and drives half_period/tone_en for a square-wave tone generator.
// Latency: FETCH+LATCH (2 cycles) per entry, then (dur+1)*TICK_DIV cycles of PLAY/GAP per note.
// Backpressure: none; pause freezes note timing, stop aborts to IDLE at the next edge.
module melody_sequencer #(
  parameter int TICK_DIV  = 2_500_000,
  parameter int GAP_TICKS = 1,
  parameter int ADDR_W    = 6,
  parameter int DIV_W     = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [DIV_W-1:0]  half_period,
  output logic              tone_en,
  output logic              note_strobe,
  output logic              busy,
  output logic              done
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [4:0]        GAP_R     = 5'(GAP_TICKS);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [3:0]        NOTE_END  = 4'hF;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  // One ROM word: pitch code in the high nibble, duration-minus-one in the low nibble.
  typedef struct packed {
    logic [3:0] note;
    logic [3:0] dur;
  } rom_entry_t;

  logic [2:0]    state;
  logic [TW-1:0] tick_cnt;
  logic [4:0]    remain;
  logic          pitched;

  rom_entry_t entry;
  logic       tick_wrap;
  logic [4:0] remain_nx;
  logic [4:0] load_remain;
  logic       entry_pitched;

  // Half-period lookup for C4..C5; every other code is silent.
  function automatic logic [DIV_W-1:0] note_half_period(input logic [3:0] code);
    case (code)
      4'd1:    return DIV_W'(32'd191113);
      4'd2:    return DIV_W'(32'd170262);
      4'd3:    return DIV_W'(32'd151686);
      4'd4:    return DIV_W'(32'd143173);
      4'd5:    return DIV_W'(32'd127551);
      4'd6:    return DIV_W'(32'd113636);
      4'd7:    return DIV_W'(32'd101239);
      4'd8:    return DIV_W'(32'd95556);
      default: return '0;
    endcase
  endfunction

  assign entry         = rom_entry_t'(rom_data);
  assign load_remain   = {1'b0, entry.dur} + 5'd1;
  assign entry_pitched = (entry.note >= 4'd1) && (entry.note <= 4'd8);
  assign tick_wrap     = (tick_cnt == TICK_LAST);
  // Remaining ticks as they will stand after this cycle's count step.
  assign remain_nx     = tick_wrap ? (remain - 5'd1) : remain;
  assign busy          = (state != S_IDLE);

  // Sequencer FSM with note timing; stop overrides everything except reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rom_addr    <= '0;
      half_period <= '0;
      tone_en     <= 1'b0;
      note_strobe <= 1'b0;
      done        <= 1'b0;
      tick_cnt    <= '0;
      remain      <= '0;
      pitched     <= 1'b0;
    end else begin
      note_strobe <= 1'b0;
      done        <= 1'b0;
      if (stop) begin
        state       <= S_IDLE;
        rom_addr    <= '0;
        half_period <= '0;
        tone_en     <= 1'b0;
        tick_cnt    <= '0;
        remain      <= '0;
        pitched     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              rom_addr <= '0;
              state    <= S_FETCH;
            end
          end
          S_FETCH: begin
            state <= S_LATCH;
          end
          S_LATCH: begin
            if (entry.note == NOTE_END) begin
              // An END at address 0 would loop forever on an empty song, so it always terminates.
              if (loop && (rom_addr != '0)) begin
                rom_addr <= '0;
                state    <= S_FETCH;
              end else begin
                done  <= 1'b1;
                state <= S_IDLE;
              end
            end else begin
              remain      <= load_remain;
              tick_cnt    <= '0;
              half_period <= note_half_period(entry.note);
              pitched     <= entry_pitched;
              tone_en     <= entry_pitched && (load_remain > GAP_R);
              note_strobe <= 1'b1;
              state       <= S_PLAY;
            end
          end
          S_PLAY, S_GAP: begin
            if (pause) begin
              tone_en <= 1'b0;
            end else begin
              tick_cnt <= tick_wrap ? '0 : (tick_cnt + TW'(1));
              remain   <= remain_nx;
              if (remain_nx == 5'd0) begin
                half_period <= '0;
                tone_en     <= 1'b0;
                rom_addr    <= rom_addr + ADDR_W'(1);
                // Running off the last address ends the song unless looping; the increment wraps to 0 either way.
                if ((rom_addr == ADDR_LAST) && !loop) begin
                  done  <= 1'b1;
                  state <= S_IDLE;
                end else begin
                  state <= S_FETCH;
                end
              end else begin
                // Tone is only audible in PLAY and ahead of the articulation gap.
                tone_en <= (state == S_PLAY) && pitched && (remain_nx > GAP_R);
                if (remain_nx <= GAP_R) begin
                  state <= S_GAP;
                end
              end
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Purpose: checks melody_sequencer cycle by cycle against a song-level timeline model.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: n/a; stimulus drives start/stop/pause/loop directly.
module tb_melody_sequencer;

  localparam int TD  = 4;
  localparam int GAP = 1;
  localparam int AW  = 4;
  localparam int DW  = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          pause;
  logic          loop;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [DW-1:0] half_period;
  logic          tone_en;
  logic          note_strobe;
  logic          busy;
  logic          done;

  logic [7:0] rom [16];

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic          busy;
    logic [AW-1:0] addr;
    logic [DW-1:0] hp;
    logic          tone;
    logic          strobe;
    logic          done;
  } obs_t;

  typedef struct {
    obs_t o;
    bit   p;
  } step_t;

  step_t exp_q[$];
  bit    ended;

  always #5 clk = ~clk;

  // Synchronous ROM: data follows the address by one cycle.
  always @(posedge clk) rom_data <= rom[rom_addr];

  melody_sequencer #(
    .TICK_DIV (TD),
    .GAP_TICKS(GAP),
    .ADDR_W   (AW),
    .DIV_W    (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .loop       (loop),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .half_period(half_period),
    .tone_en    (tone_en),
    .note_strobe(note_strobe),
    .busy       (busy),
    .done       (done)
  );

  function automatic int hp_of(input int code);
    case (code)
      1: return 191113;
      2: return 170262;
      3: return 151686;
      4: return 143173;
      5: return 127551;
      6: return 113636;
      7: return 101239;
      8: return 95556;
      default: return 0;
    endcase
  endfunction

  function automatic obs_t mk(input bit b, input int a, input int hp, input bit t, input bit s, input bit d);
    obs_t r;
    r.busy   = b;
    r.addr   = a[AW-1:0];
    r.hp     = hp[DW-1:0];
    r.tone   = t;
    r.strobe = s;
    r.done   = d;
    return r;
  endfunction

  function automatic obs_t sample();
    return {busy, rom_addr, half_period, tone_en, note_strobe, done};
  endfunction

  task automatic check(input string tag, input int idx, input obs_t e);
    obs_t g;
    g = sample();
    tests++;
    assert (g === e) else begin
      fails++;
      $error("FAIL %s step=%0d got busy=%b addr=%0d hp=%0d tone=%b strobe=%b done=%b want busy=%b addr=%0d hp=%0d tone=%b strobe=%b done=%b",
             tag, idx, g.busy, g.addr, g.hp, g.tone, g.strobe, g.done,
             e.busy, e.addr, e.hp, e.tone, e.strobe, e.done);
    end
  endtask

  task automatic push(input obs_t o, input bit p);
    step_t s;
    s.o = o;
    s.p = p;
    exp_q.push_back(s);
  endtask

  // Song-level timeline: every entry costs FETCH+LATCH, every note then lasts (dur+1)*TD cycles,
  // audible for the first (dur+1-GAP)*TD of them; a pause inserts silent frozen copies of one cycle.
  task automatic build(input bit lp, input int pn, input int pk, input int pc, input int budget);
    int a;
    int notes;
    int code;
    int dur;
    int len;
    int on;
    int hp;
    obs_t o;
    exp_q.delete();
    ended = 1'b0;
    a     = 0;
    notes = 0;
    while (!ended && (exp_q.size() < budget)) begin
      push(mk(1, a, 0, 0, 0, 0), 0);
      push(mk(1, a, 0, 0, 0, 0), 0);
      code = rom[a] >> 4;
      dur  = rom[a] & 15;
      if (code == 15) begin
        if (lp && a != 0) begin
          a = 0;
        end else begin
          push(mk(0, a, 0, 0, 0, 1), 0);
          ended = 1'b1;
        end
      end else begin
        len = (dur + 1) * TD;
        on  = (code >= 1 && code <= 8 && dur + 1 > GAP) ? (dur + 1 - GAP) * TD : 0;
        hp  = hp_of(code);
        for (int k = 0; k < len; k++) begin
          o = mk(1, a, hp, k < on, k == 0, 0);
          if (pc > 0 && notes == pn && k == pk) begin
            push(o, 1);
            o.tone   = 1'b0;
            o.strobe = 1'b0;
            for (int j = 1; j <= pc; j++) push(o, j < pc);
          end else begin
            push(o, 0);
          end
        end
        notes++;
        if (a == 15) begin
          if (lp) begin
            a = 0;
          end else begin
            push(mk(0, 0, 0, 0, 0, 1), 0);
            ended = 1'b1;
          end
        end else begin
          a++;
        end
      end
    end
    if (exp_q.size() > budget) begin
      while (exp_q.size() > budget) void'(exp_q.pop_back());
      ended = 1'b0;
    end
  endtask

  // Plays one song; a song cut short by the budget is aborted with stop on its last modelled cycle.
  task automatic run_song(input string tag, input bit lp, input int pn, input int pk, input int pc, input int budget);
    int n;
    build(lp, pn, pk, pc, budget);
    n = exp_q.size();
    loop = lp;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, i, exp_q[i].o);
      pause = exp_q[i].p;
      if (i == n - 1 && !ended) begin
        stop  = 1'b1;
        start = 1'($urandom_range(0, 1));
      end else begin
        start = exp_q[i].o.busy && ($urandom_range(0, 3) == 0);
      end
    end
    @(negedge clk);
    if (ended) check({tag, "_idle"}, n, mk(0, exp_q[n-1].o.addr, 0, 0, 0, 0));
    else       check({tag, "_stop"}, n, mk(0, 0, 0, 0, 0, 0));
    stop  = 1'b0;
    pause = 1'b0;
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    check({tag, "_startstop"}, n + 1, mk(0, 0, 0, 0, 0, 0));
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    check({tag, "_stay_idle"}, n + 2, mk(0, 0, 0, 0, 0, 0));
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    pause = 1'b0;
    loop  = 1'b0;
    fill_rom(8'hF0);
    repeat (3) @(negedge clk);
    check("reset", 0, mk(0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    @(negedge clk);
    check("post_reset", 1, mk(0, 0, 0, 0, 0, 0));

    // Single E4 note then END.
    fill_rom(8'hF0);
    rom[0] = 8'h31;
    run_song("t1_note", 0, 0, 0, 0, 1000);

    // Three-tick rest.
    rom[0] = 8'h02;
    run_song("t2_rest", 0, 0, 0, 0, 1000);

    // G4 with a 10-cycle pause inside PLAY.
    rom[0] = 8'h53;
    run_song("t3_pause", 0, 0, 5, 10, 1000);

    // Looping two-entry song, aborted by stop.
    rom[0] = 8'h10;
    rom[1] = 8'hF0;
    run_song("t4_loop", 1, 0, 0, 0, 60);

    // END at address 0 terminates even with loop set.
    rom[0] = 8'hF0;
    run_song("t4_end0", 1, 0, 0, 0, 1000);

    // Stop during the articulation gap.
    rom[0] = 8'h31;
    run_song("t5_stop_gap", 0, 0, 0, 0, 8);

    // Full ROM of C5 notes, running off the last address.
    fill_rom(8'h80);
    run_song("t6_full", 0, 0, 0, 0, 1000);

    // Reset in the middle of a note.
    fill_rom(8'hF0);
    rom[0] = 8'h33;
    loop   = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid", 0, mk(0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_after", 1, mk(0, 0, 0, 0, 0, 0));

    // Randomized songs, loop settings, pauses and stop points.
    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < 16; i++) begin
        rom[i] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3))};
      end
      run_song($sformatf("rand%0d", r), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 6),
               $urandom_range(20, 300));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
